nfcv2_wide_to_narrow_fifo: RTL and testbench

Width-converting FIFO for the NAND program path: 32-bit words from the DMA/host side go in, 16-bit halfwords come out to the NAND data-bus driver. It mirrors the 16-to-32 read-path buffer. The block is built from a simple dual-port RAM core plus a two-word output prefetch stage, with valid/ready handshakes on both sides. Within each word the low halfword is emitted first.

---
 rtl/nfcv2_wide_to_narrow_fifo.sv | 171 +++++++++++++++++
 tb/tb_nfcv2_wide_to_narrow_fifo.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/nfcv2_wide_to_narrow_fifo.sv
// ---------------------------------------------------------------------------
// nfcv2_wide_to_narrow_fifo
//
// Width-converting FIFO on the NAND program path. 32-bit words from the
// DMA/host side are stored in a simple dual-port RAM. They are read out through
// a two-word output stage (hold + prefetch). The NAND data-bus driver receives
// them as 16-bit halfwords, low halfword of each word first.
//
// Ports:
//   clk         single clock, all logic on posedge
//   rst         synchronous active-high reset
//   i_flush     synchronous clear of all contents (same effect as rst)
//   i_wvalid    write word valid
//   i_wdata     32-bit write word
//   o_wready    write accepted on an edge where i_wvalid & o_wready
//   o_rvalid    o_rdata holds a valid halfword
//   o_rdata     current 16-bit halfword
//   i_rready    halfword consumed on an edge where o_rvalid & i_rready
//   o_hw_count  halfwords held (RAM + in-flight read + prefetch + hold)
// ---------------------------------------------------------------------------
module nfcv2_wide_to_narrow_fifo #(
    parameter int ADDR_WIDTH = 12,
    parameter int MEM_DEPTH  = 4096   // must equal 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    input  logic                  i_wvalid,
    input  logic [31:0]           i_wdata,
    output logic                  o_wready,
    output logic                  o_rvalid,
    output logic [15:0]           o_rdata,
    input  logic                  i_rready,
    output logic [ADDR_WIDTH+1:0] o_hw_count
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam int CW = ADDR_WIDTH + 2;
    localparam logic [PW-1:0] DEPTH_C = PW'(MEM_DEPTH);

    // RAM core and its registered read port
    logic [31:0]   mem_q [0:MEM_DEPTH-1];
    logic [31:0]   rdata_q;

    // Pointers carry one extra bit so that full and empty can be told apart
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;

    // Output stage
    logic [31:0]   hold_q, hold_d;
    logic          hold_v_q, hold_v_d;
    logic          sel_q, sel_d;
    logic [31:0]   pf_q, pf_d;
    logic          pf_v_q, pf_v_d;
    logic          inflight_q, inflight_d;

    logic [PW-1:0] ram_cnt;
    logic          clear;
    logic          wr_fire;
    logic          consume;
    logic          release_hold;
    logic          hold_keep;
    logic [1:0]    stage_after;
    logic          rd_issue;
    logic [CW-1:0] words_held;
    logic [CW-1:0] hold_part;

    // Handshake and read-issue decisions. A read issues only if the stage
    // (after this cycle's consume) still has room for the word it returns.
    // Because of this, hold + prefetch + in-flight never exceeds two words.
    always_comb begin
        ram_cnt      = wptr_q - rptr_q;
        clear        = rst | i_flush;
        o_wready     = (ram_cnt != DEPTH_C) & ~clear;
        wr_fire      = i_wvalid & o_wready;
        consume      = hold_v_q & i_rready;
        release_hold = consume & sel_q;
        hold_keep    = hold_v_q & ~release_hold;
        stage_after  = {1'b0, hold_keep} + {1'b0, pf_v_q} + {1'b0, inflight_q};
        rd_issue     = (ram_cnt != '0) & (stage_after < 2'd2) & ~clear;
    end

    // Next-state logic for pointers and the output stage. When hold frees, the
    // prefetch word (the older one) moves in first. Returning RAM data then
    // backfills the prefetch register.
    always_comb begin
        wptr_d     = wptr_q + PW'(wr_fire);
        rptr_d     = rptr_q + PW'(rd_issue);
        inflight_d = rd_issue;
        hold_d     = hold_q;
        hold_v_d   = hold_v_q;
        sel_d      = sel_q;
        pf_d       = pf_q;
        pf_v_d     = pf_v_q;

        if (!hold_keep) begin
            sel_d = 1'b0;
            if (pf_v_q) begin
                hold_d   = pf_q;
                hold_v_d = 1'b1;
                if (inflight_q) begin
                    pf_d   = rdata_q;
                    pf_v_d = 1'b1;
                end else begin
                    pf_v_d = 1'b0;
                end
            end else if (inflight_q) begin
                hold_d   = rdata_q;
                hold_v_d = 1'b1;
            end else begin
                hold_v_d = 1'b0;
            end
        end else begin
            // hold stays, so a consume here must have been the low half
            if (consume) begin
                sel_d = 1'b1;
            end
            if (inflight_q) begin
                pf_d   = rdata_q;
                pf_v_d = 1'b1;
            end
        end
    end

    // State registers. Flush behaves exactly like reset and overrides any
    // concurrent handshake.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            hold_q     <= '0;
            hold_v_q   <= 1'b0;
            sel_q      <= 1'b0;
            pf_q       <= '0;
            pf_v_q     <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            hold_q     <= hold_d;
            hold_v_q   <= hold_v_d;
            sel_q      <= sel_d;
            pf_q       <= pf_d;
            pf_v_q     <= pf_v_d;
            inflight_q <= inflight_d;
        end
    end

    // RAM array without reset, so it maps onto block RAM. A read never targets
    // the slot being written: reads need ram_cnt != 0 and writes need ram_cnt
    // below depth, so the two addresses differ.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wptr_q[ADDR_WIDTH-1:0]] <= i_wdata;
        end
        if (rd_issue) begin
            rdata_q <= mem_q[rptr_q[ADDR_WIDTH-1:0]];
        end
    end

    // Output mux and occupancy. The hold word counts 2 halfwords before its
    // low half is taken and 1 afterwards.
    always_comb begin
        o_rvalid   = hold_v_q;
        o_rdata    = sel_q ? hold_q[31:16] : hold_q[15:0];
        words_held = CW'(ram_cnt) + CW'(inflight_q) + CW'(pf_v_q);
        hold_part  = hold_v_q ? (sel_q ? CW'(1) : CW'(2)) : '0;
        o_hw_count = (words_held << 1) + hold_part;
    end

endmodule

// File: tb/tb_nfcv2_wide_to_narrow_fifo.sv
// Directed bench for the 32-to-16 program-path FIFO. It uses a small RAM
// (16 words) so that the full and wrap conditions occur quickly. A halfword
// queue plus an occupancy counter serve as the reference for output order and
// o_hw_count.
module tb_nfcv2_wide_to_narrow_fifo;

   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_flush = 1'b0;
   logic          i_wvalid = 1'b0;
   logic [31:0]   i_wdata = '0;
   logic          o_wready;
   logic          o_rvalid;
   logic [15:0]   o_rdata;
   logic          i_rready = 1'b0;
   logic [AW+1:0] o_hw_count;

   int            assertCount = 0;
   int            failCount = 0;
   int            modelCount = 0;
   int            consumedCount = 0;
   logic [15:0]   modelQ[$];
   logic          lastAccepted = 1'b0;

   nfcv2_wide_to_narrow_fifo #(.ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_flush    (i_flush),
      .i_wvalid   (i_wvalid),
      .i_wdata    (i_wdata),
      .o_wready   (o_wready),
      .o_rvalid   (o_rvalid),
      .o_rdata    (o_rdata),
      .i_rready   (i_rready),
      .o_hw_count (o_hw_count)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Guard against a hung run
   initial begin
      #600000;
      $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, update the reference model from the handshakes
   // that will occur on the coming edge, then advance to just after that edge.
   task automatic applyStimulus(input logic wv, input logic [31:0] wd, input logic rr, input logic fl);
      logic wf;
      logic rf;
      i_wvalid = wv;
      i_wdata  = wd;
      i_rready = rr;
      i_flush  = fl;
      #1;
      wf = i_wvalid & o_wready;
      rf = o_rvalid & i_rready;
      if (rst || fl) begin
         modelQ.delete();
         modelCount = 0;
      end else begin
         if (rf === 1'b1) begin
            if (modelQ.size() == 0) begin
               checkOutput("rvalid_when_empty", {31'b0, o_rvalid}, 32'd0);
            end else begin
               checkOutput("rdata_order", {16'b0, o_rdata}, {16'b0, modelQ.pop_front()});
               modelCount--;
               consumedCount++;
            end
         end
         if (wf === 1'b1) begin
            modelQ.push_back(wd[15:0]);
            modelQ.push_back(wd[31:16]);
            modelCount += 2;
         end
      end
      lastAccepted = (wf === 1'b1);
      @(posedge clk);
      #1;
   endtask

   // Consume everything still held, then confirm the FIFO reads empty
   task automatic drainAll(input string tag);
      int cycles = 0;
      while (modelQ.size() > 0 && cycles < 200) begin
         applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
         cycles++;
      end
      checkOutput({tag, "_drain_count"}, {26'b0, o_hw_count}, 32'd0);
      checkOutput({tag, "_drain_rvalid"}, {31'b0, o_rvalid}, 32'd0);
   endtask

   initial begin
      int k;
      int cycles;
      int accepted;
      bit started;
      bit seen;

      // Reset: writes offered during reset must be refused
      $display("[TB] reset");
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
         checkOutput("reset_wready", {31'b0, o_wready}, 32'd0);
      end
      rst = 1'b0;
      #1;
      checkOutput("reset_rvalid", {31'b0, o_rvalid}, 32'd0);
      checkOutput("reset_count", {26'b0, o_hw_count}, 32'd0);
      checkOutput("reset_rdata", {16'b0, o_rdata}, 32'd0);
      checkOutput("reset_wready_release", {31'b0, o_wready}, 32'd1);

      // Single word: valid two edges after the write, low half first
      $display("[TB] single word");
      applyStimulus(1'b1, 32'hBEEF_1234, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("single_rvalid_edge1", {31'b0, o_rvalid}, 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("single_rvalid_edge2", {31'b0, o_rvalid}, 32'd1);
      checkOutput("single_low", {16'b0, o_rdata}, 32'h0000_1234);
      checkOutput("single_count", {26'b0, o_hw_count}, 32'd2);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("single_high_rvalid", {31'b0, o_rvalid}, 32'd1);
      checkOutput("single_high", {16'b0, o_rdata}, 32'h0000_BEEF);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("single_done_rvalid", {31'b0, o_rvalid}, 32'd0);
      checkOutput("single_done_count", {26'b0, o_hw_count}, 32'd0);

      // Streaming: 1000 sequential words, consumer always ready
      $display("[TB] streaming");
      k = 0;
      cycles = 0;
      started = 1'b0;
      consumedCount = 0;
      while ((k < 1000 || modelQ.size() > 0) && cycles < 6000) begin
         applyStimulus(k < 1000, 32'(k), 1'b1, 1'b0);
         if (lastAccepted) k++;
         if (started && modelCount > 0) begin
            checkOutput("stream_bubble", {31'b0, o_rvalid}, 32'd1);
         end
         if (o_rvalid) started = 1'b1;
         cycles++;
      end
      checkOutput("stream_words", 32'(k), 32'd1000);
      checkOutput("stream_halfwords", 32'(consumedCount), 32'd2000);
      checkOutput("stream_count", {26'b0, o_hw_count}, 32'd0);

      // Full: DEPTH + 2 words fit, then writes stall until a whole word leaves
      $display("[TB] full");
      accepted = 0;
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'b1, 32'h1000_0000 + 32'(accepted), 1'b0, 1'b0);
         if (lastAccepted) accepted++;
      end
      checkOutput("full_accepted", 32'(accepted), 32'd18);
      checkOutput("full_wready", {31'b0, o_wready}, 32'd0);
      checkOutput("full_count", {26'b0, o_hw_count}, 32'd36);
      applyStimulus(1'b1, 32'h1000_0000 + 32'(accepted), 1'b1, 1'b0);
      checkOutput("full_first_consume_write", {31'b0, lastAccepted}, 32'd0);
      checkOutput("full_after_low_wready", {31'b0, o_wready}, 32'd0);
      checkOutput("full_after_low_count", {26'b0, o_hw_count}, 32'd35);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      seen = o_wready;
      for (int i = 0; i < 2; i++) begin
         if (!seen) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
            seen = o_wready;
         end
      end
      checkOutput("full_wready_release", {31'b0, seen}, 32'd1);
      checkOutput("full_release_count", {26'b0, o_hw_count}, 32'(modelCount));
      drainAll("full");

      // Wrap: random handshakes over many pointer laps
      $display("[TB] wrap");
      accepted = 0;
      cycles = 0;
      while (accepted < 200 && cycles < 5000) begin
         applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
         if (lastAccepted) accepted++;
         checkOutput("wrap_count", {26'b0, o_hw_count}, 32'(modelCount));
         cycles++;
      end
      checkOutput("wrap_accepted", 32'(accepted), 32'd200);
      drainAll("wrap");

      // Flush mid-stream with concurrent write and read handshakes
      $display("[TB] flush");
      accepted = 0;
      cycles = 0;
      while (accepted < 10 && cycles < 50) begin
         applyStimulus(1'b1, {16'hA000 + 16'(accepted), 16'hB000 + 16'(accepted)}, 1'b0, 1'b0);
         if (lastAccepted) accepted++;
         cycles++;
      end
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("flush_pre_high", {16'b0, o_rdata}, 32'h0000_A000);
      checkOutput("flush_pre_count", {26'b0, o_hw_count}, 32'd19);
      applyStimulus(1'b1, 32'hFFFF_EEEE, 1'b1, 1'b1);
      checkOutput("flush_rvalid", {31'b0, o_rvalid}, 32'd0);
      checkOutput("flush_count", {26'b0, o_hw_count}, 32'd0);
      applyStimulus(1'b1, 32'hCAFE_5678, 1'b0, 1'b0);
      checkOutput("flush_new_write", {31'b0, lastAccepted}, 32'd1);
      cycles = 0;
      while (!o_rvalid && cycles < 5) begin
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
         cycles++;
      end
      checkOutput("flush_new_rvalid", {31'b0, o_rvalid}, 32'd1);
      checkOutput("flush_new_low", {16'b0, o_rdata}, 32'h0000_5678);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("flush_new_high", {16'b0, o_rdata}, 32'h0000_CAFE);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("flush_end_rvalid", {31'b0, o_rvalid}, 32'd0);
      checkOutput("flush_end_count", {26'b0, o_hw_count}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
